// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder: one full-adder cell sequenced LSB first over DWL slices
module serial_add_sequencer #(
    parameter int DWL = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DWL-1:0] In1,
    input  logic [DWL-1:0] In2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DWL:0]   Sum,
    output logic           busy
);

    localparam int CW = ($clog2(DWL) > 1) ? $clog2(DWL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWL - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DWL-1:0] a_reg;
    logic [DWL-1:0] b_reg;
    logic [DWL-1:0] result;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           s;
    logic           cout;
    logic           load;
    logic           last;

    assign s    = a_reg[0] ^ b_reg[0] ^ carry;
    assign cout = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign load = (state == IDLE) && in_valid;
    assign last = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // The final slice bypasses the result reg so Sum is complete on entry to DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
        end else if (load) begin
            a_reg <= In1;
            b_reg <= In2;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_reg  <= a_reg >> 1;
            b_reg  <= b_reg >> 1;
            result <= {s, result[DWL-1:1]};
            carry  <= cout;
            if (last) begin
                cnt <= '0;
                Sum <= {cout, s, result[DWL-1:1]};
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
